// File: rtl/duty_ramp_sequencer.sv
// -----------------------------------------------------------------------------
// duty_ramp_sequencer
//   Produces the duty-cycle word for the downstream PWM stage. It supports:
//     - manual hold
//     - up sawtooth
//     - down sawtooth
//     - triangle ("breathing") ramp, with a dwell at each extreme
//   The duty word only moves on a PWM period-wrap strobe, so no PWM period
//   ever sees a mid-period duty change.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high, highest priority
//   enable       0 freezes the sequencer in IDLE and holds the duty word
//   mode         00 manual, 01 saw up, 10 saw down, 11 triangle
//   manual_duty  duty loaded on each period_tick in manual mode
//   step_div     ramp steps once every step_div+1 period_tick pulses
//   period_tick  1-cycle strobe from the PWM at counter wrap
//   duty_cycle   registered duty word to the PWM
//   duty_upd     1-cycle pulse while duty_cycle shows a new value
//   at_top       1-cycle pulse when a ramp step lands on DMAX
//   at_bot       1-cycle pulse when a ramp step lands on 0
// -----------------------------------------------------------------------------
module duty_ramp_sequencer #(
  parameter int DUTY_W = 4,
  parameter int DIV_W  = 8,
  parameter int DWELL  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DUTY_W-1:0] manual_duty,
  input  logic [DIV_W-1:0]  step_div,
  input  logic              period_tick,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              duty_upd,
  output logic              at_top,
  output logic              at_bot
);

  localparam logic [DUTY_W-1:0] DMAX       = '1;
  localparam int                DW_W       = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
  localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'((DWELL > 0) ? DWELL - 1 : 0);

  localparam logic [1:0] M_MAN = 2'b00;
  localparam logic [1:0] M_UP  = 2'b01;
  localparam logic [1:0] M_DN  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RISE,
    S_FALL,
    S_DWELL_TOP,
    S_DWELL_BOT
  } state_t;

  state_t            r_state, w_state_nxt, w_eff;
  logic [DIV_W-1:0]  r_presc, w_presc_nxt;
  logic [DW_W-1:0]   r_dwell, w_dwell_nxt;
  logic [DUTY_W-1:0] r_duty,  w_duty_nxt;
  logic              r_upd, r_top, r_bot;
  logic              w_top_nxt, w_bot_nxt, w_step;

  // One step up or down; callers guarantee the value is not already at
  // the limit, so these never wrap on their own.
  function automatic logic [DUTY_W-1:0] f_duty_up(input logic [DUTY_W-1:0] d);
    return d + DUTY_W'(1);
  endfunction

  function automatic logic [DUTY_W-1:0] f_duty_dn(input logic [DUTY_W-1:0] d);
    return d - DUTY_W'(1);
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_dwell_nxt = r_dwell;
    w_duty_nxt  = r_duty;
    w_top_nxt   = 1'b0;
    w_bot_nxt   = 1'b0;

    // Prescaler above a freshly lowered step_div also counts as a step.
    w_step = (r_presc >= step_div);

    // Saw modes force their direction immediately.
    // Triangle keeps whatever phase it is in, including a dwell.
    unique case (mode)
      M_UP:    w_eff = S_RISE;
      M_DN:    w_eff = S_FALL;
      default: w_eff = r_state;
    endcase

    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_presc_nxt = '0;
      w_dwell_nxt = '0;
    end else if (period_tick) begin
      if (mode == M_MAN) begin
        w_state_nxt = S_IDLE;
        w_presc_nxt = '0;
        w_dwell_nxt = '0;
        w_duty_nxt  = manual_duty;
      end else if (r_state == S_IDLE) begin
        // Entry tick only picks a direction; the first step comes later.
        w_state_nxt = (mode == M_DN) ? S_FALL : S_RISE;
      end else begin
        w_state_nxt = w_eff;
        if (w_eff != r_state) begin
          w_dwell_nxt = '0;
        end
        if (w_step) begin
          w_presc_nxt = '0;
          case (w_eff)
            S_RISE: begin
              if (r_duty != DMAX) begin
                w_duty_nxt = f_duty_up(r_duty);
                w_top_nxt  = (f_duty_up(r_duty) == DMAX);
              end else if (mode == M_UP) begin
                w_duty_nxt = '0;
                w_bot_nxt  = 1'b1;
              end else begin
                w_state_nxt = (DWELL > 0) ? S_DWELL_TOP : S_FALL;
                w_dwell_nxt = '0;
              end
            end
            S_FALL: begin
              if (r_duty != '0) begin
                w_duty_nxt = f_duty_dn(r_duty);
                w_bot_nxt  = (f_duty_dn(r_duty) == '0);
              end else if (mode == M_DN) begin
                w_duty_nxt = DMAX;
                w_top_nxt  = 1'b1;
              end else begin
                w_state_nxt = (DWELL > 0) ? S_DWELL_BOT : S_RISE;
                w_dwell_nxt = '0;
              end
            end
            S_DWELL_TOP: begin
              if (r_dwell == DWELL_LAST) begin
                w_state_nxt = S_FALL;
                w_dwell_nxt = '0;
              end else begin
                w_dwell_nxt = r_dwell + DW_W'(1);
              end
            end
            S_DWELL_BOT: begin
              if (r_dwell == DWELL_LAST) begin
                w_state_nxt = S_RISE;
                w_dwell_nxt = '0;
              end else begin
                w_dwell_nxt = r_dwell + DW_W'(1);
              end
            end
            default: ;
          endcase
        end else begin
          w_presc_nxt = r_presc + DIV_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_presc <= '0;
      r_dwell <= '0;
      r_duty  <= '0;
      r_upd   <= 1'b0;
      r_top   <= 1'b0;
      r_bot   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_dwell <= w_dwell_nxt;
      r_duty  <= w_duty_nxt;
      r_upd   <= (w_duty_nxt != r_duty);
      r_top   <= w_top_nxt;
      r_bot   <= w_bot_nxt;
    end
  end

  assign duty_cycle = r_duty;
  assign duty_upd   = r_upd;
  assign at_top     = r_top;
  assign at_bot     = r_bot;

endmodule

// File: tb/tb_duty_ramp_sequencer.sv
// -----------------------------------------------------------------------------
// tb_duty_ramp_sequencer
//   Self-checking bench for duty_ramp_sequencer. A behavioural model tracks
//   duty, ramp direction, remaining hold slots and tick count, and it predicts
//   duty_cycle / duty_upd / at_top / at_bot after every clock edge.
// -----------------------------------------------------------------------------
module tb_duty_ramp_sequencer;

  localparam int DUTY_W = 4;
  localparam int DIV_W  = 8;
  localparam int DWELL  = 2;
  localparam int DMAX   = (1 << DUTY_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic [DUTY_W-1:0] manual_duty = '0;
  logic [DIV_W-1:0]  step_div = '0;
  logic              period_tick = 1'b0;
  logic [DUTY_W-1:0] duty_cycle;
  logic              duty_upd, at_top, at_bot;

  int n_checks = 0;
  int n_fails  = 0;

  // Model state.
  int m_duty = 0;
  int m_dir  = 0;   // +1 rising, -1 falling
  int m_hold = 0;   // remaining held step slots after a triangle turnaround
  int m_cnt  = 0;   // ticks since last step
  bit m_run  = 0;   // 0 = idle
  bit e_upd = 0, e_top = 0, e_bot = 0;

  duty_ramp_sequencer #(.DUTY_W(DUTY_W), .DIV_W(DIV_W), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .manual_duty(manual_duty), .step_div(step_div), .period_tick(period_tick),
    .duty_cycle(duty_cycle), .duty_upd(duty_upd), .at_top(at_top), .at_bot(at_bot)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    int nd;
    bit step;
    nd = m_duty;
    e_top = 0;
    e_bot = 0;
    if (rst) begin
      m_duty = 0; m_run = 0; m_cnt = 0; m_hold = 0; m_dir = 0; e_upd = 0;
      return;
    end
    if (!enable) begin
      m_run = 0; m_cnt = 0; m_hold = 0;
    end else if (period_tick) begin
      if (mode == 2'b00) begin
        m_run = 0; m_cnt = 0; m_hold = 0;
        nd = int'(manual_duty);
      end else if (!m_run) begin
        m_run = 1;
        m_dir = (mode == 2'b10) ? -1 : 1;
        m_hold = 0;
      end else begin
        if (mode == 2'b01) begin m_dir = 1;  m_hold = 0; end
        if (mode == 2'b10) begin m_dir = -1; m_hold = 0; end
        step = (m_cnt >= int'(step_div));
        m_cnt = step ? 0 : m_cnt + 1;
        if (step) begin
          if (m_hold > 0) begin
            m_hold--;
          end else if (m_dir == 1) begin
            if (nd < DMAX) nd++;
            else if (mode == 2'b01) nd = 0;
            else begin m_dir = -1; m_hold = DWELL; end
          end else begin
            if (nd > 0) nd--;
            else if (mode == 2'b10) nd = DMAX;
            else begin m_dir = 1; m_hold = DWELL; end
          end
          if (nd != m_duty) begin
            e_top = (nd == DMAX);
            e_bot = (nd == 0);
          end
        end
      end
    end
    e_upd = (nd != m_duty);
    m_duty = nd;
  endtask

  // Advance one clock: DUT and model see the same inputs, outputs read at negedge.
  task automatic clk_step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  function automatic logic [6:0] obs();
    return {duty_cycle, duty_upd, at_top, at_bot};
  endfunction

  function automatic logic [6:0] expv();
    return {DUTY_W'(m_duty), e_upd, e_top, e_bot};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      enable = 1'(($urandom) & 1); mode = 2'($urandom); manual_duty = DUTY_W'($urandom);
      step_div = DIV_W'($urandom); period_tick = 1'($urandom);
      clk_step();
      n_checks++;
      if (obs() !== 7'd0) begin
        n_fails++;
        $display("FAIL reset[%0d]: got {duty,upd,top,bot}=%b required 0000000", i, obs());
      end
    end
    rst = 1'b0; period_tick = 1'b0; enable = 1'b0;
    clk_step();
  endtask

  task automatic test_manual();
    enable = 1'b1; mode = 2'b00; manual_duty = 4'd9; period_tick = 1'b1;
    clk_step();
    n_checks++;
    if (obs() !== {4'd9, 3'b100} || obs() !== expv()) begin
      n_fails++;
      $display("FAIL manual_load: got %b required %b", obs(), {4'd9, 3'b100});
    end
    clk_step();
    n_checks++;
    if (obs() !== {4'd9, 3'b000} || obs() !== expv()) begin
      n_fails++;
      $display("FAIL manual_same: got %b required %b", obs(), {4'd9, 3'b000});
    end
  endtask

  task automatic test_saw_up();
    manual_duty = 4'd0; mode = 2'b00; period_tick = 1'b1;
    clk_step();
    mode = 2'b01; step_div = '0;
    clk_step();  // entry tick, no step
    for (int i = 0; i < 20; i++) begin
      clk_step();
      n_checks++;
      if (obs() !== expv() || int'(duty_cycle) != (i + 1) % (DMAX + 1)) begin
        n_fails++;
        $display("FAIL saw_up[%0d]: got %b required %b", i, obs(), expv());
      end
    end
  endtask

  task automatic test_triangle();
    int run15;
    bit checked;
    run15 = 0; checked = 0;
    mode = 2'b00; manual_duty = 4'd0; period_tick = 1'b1;
    clk_step();
    mode = 2'b11; step_div = 8'd2;
    clk_step();
    for (int i = 0; i < 150; i++) begin
      clk_step();
      n_checks++;
      if (obs() !== expv()) begin
        n_fails++;
        $display("FAIL triangle[%0d]: got %b required %b", i, obs(), expv());
      end
      if (duty_cycle == 4'(DMAX)) run15++;
      else if (run15 > 0 && !checked) begin
        checked = 1;
        n_checks++;
        if (run15 != (DWELL + 2) * 3) begin
          n_fails++;
          $display("FAIL triangle_top_hold: got %0d cycles required %0d", run15, (DWELL + 2) * 3);
        end
      end
    end
  endtask

  task automatic test_enable_freeze();
    mode = 2'b00; manual_duty = 4'd6; period_tick = 1'b1;
    clk_step();
    mode = 2'b01; step_div = '0;
    clk_step();
    clk_step();
    n_checks++;
    if (duty_cycle !== 4'd7 || obs() !== expv()) begin
      n_fails++;
      $display("FAIL freeze_setup: got %b required %b", obs(), expv());
    end
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      period_tick = 1'($urandom);
      clk_step();
      n_checks++;
      if (obs() !== {4'd7, 3'b000} || obs() !== expv()) begin
        n_fails++;
        $display("FAIL freeze_hold[%0d]: got %b required %b", i, obs(), {4'd7, 3'b000});
      end
    end
    enable = 1'b1; mode = 2'b10; period_tick = 1'b1;
    clk_step();
    n_checks++;
    if (obs() !== {4'd7, 3'b000} || obs() !== expv()) begin
      n_fails++;
      $display("FAIL resume_entry: got %b required %b", obs(), {4'd7, 3'b000});
    end
    clk_step();
    n_checks++;
    if (obs() !== {4'd6, 3'b100} || obs() !== expv()) begin
      n_fails++;
      $display("FAIL resume_fall: got %b required %b", obs(), {4'd6, 3'b100});
    end
  endtask

  task automatic test_reset_in_dwell();
    bit found;
    found = 0;
    mode = 2'b00; manual_duty = 4'd13; period_tick = 1'b1;
    clk_step();
    mode = 2'b11; step_div = '0;
    for (int i = 0; i < 50 && !found; i++) begin
      clk_step();
      found = (m_run && m_dir == -1 && m_hold > 0 && m_duty == DMAX);
    end
    n_checks++;
    if (!found || obs() !== expv()) begin
      n_fails++;
      $display("FAIL dwell_reach: got %b required %b (dwell reached=%0d)", obs(), expv(), found);
    end
    rst = 1'b1; period_tick = 1'b1;
    clk_step();
    rst = 1'b0;
    n_checks++;
    if (obs() !== 7'd0 || obs() !== expv()) begin
      n_fails++;
      $display("FAIL reset_in_dwell: got %b required 0000000", obs());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      enable      = ($urandom_range(0, 9) != 0);
      mode        = 2'($urandom);
      manual_duty = DUTY_W'($urandom);
      step_div    = DIV_W'($urandom_range(0, 3));
      period_tick = ($urandom_range(0, 9) < 6);
      clk_step();
      n_checks++;
      if (obs() !== expv()) begin
        n_fails++;
        $display("FAIL random[%0d]: got %b required %b", i, obs(), expv());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_manual();
    test_saw_up();
    test_triangle();
    test_enable_freeze();
    test_reset_in_dwell();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
